// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampling UART receiver, 8 data bits LSB first, one stop bit.
// Define UART_RX_PARITY_EN to insert one even-parity bit between the data and stop bits.
module uart_rx_sampler #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ferr_o,
  output logic       perr_o,
  output logic       busy_o
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_prev;
  logic [1:0]    r_flush;
  logic [TW-1:0] r_tick_cnt;
  logic [3:0]    r_sample;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx_s;
  logic          w_tick;
  logic          w_fall;
  logic          w_mid_start;
  logic          w_bit_end;

  assign w_rx_s      = r_sync2;
  assign w_tick      = (r_tick_cnt == TW'(DIV - 1));
  // Edge detection waits until the reset-forced ones have left the pipeline,
  // so a line that is already low after reset is treated as a break.
  assign w_fall      = (r_flush == 2'd3) && r_rx_prev && !w_rx_s;
  assign w_mid_start = w_tick && (r_sample == 4'd7);
  assign w_bit_end   = w_tick && (r_sample == 4'd15);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_flush   <= 2'd0;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      if (r_flush != 2'd3) begin
        r_flush <= r_flush + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_state_next = S_START;
      S_START:  if (w_mid_start) w_state_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP:   if (w_bit_end) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Counters are zero whenever the FSM sits in IDLE, including the cycle it arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tick_cnt <= '0;
      r_sample   <= 4'd0;
    end else if ((r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
      r_tick_cnt <= '0;
      r_sample   <= 4'd0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if ((r_state == S_START) && w_mid_start) begin
        r_sample <= 4'd0;
      end else if (w_tick) begin
        r_sample <= r_sample + 4'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic r_perr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par_err <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      if (r_state == S_START) begin
        r_par_err <= 1'b0;
      end else if ((r_state == S_PARITY) && w_bit_end) begin
        r_par_err <= w_rx_s ^ (^r_shift);
      end else if ((r_state == S_STOP) && w_bit_end) begin
        r_perr <= r_par_err;
      end
    end
  end

  assign perr_o = r_perr;
`else
  assign perr_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_state == S_START) begin
        r_bit_cnt <= 3'd0;
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift   <= {w_rx_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else if ((r_state == S_STOP) && w_bit_end) begin
        if (w_rx_s) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ferr  <= 1'b1;
        end
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign ferr_o  = r_ferr;
  assign busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames against an event-list model of the receiver outputs.
// Build with UART_RX_PARITY_EN defined to also exercise the parity bit.
module tb_uart_rx_sampler;

  localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // start edge -> 2 sync flops, half a bit to mid-start, (8 data + parity + stop) bits, output register
  localparam int LAT = 2 + BIT_CLKS / 2 + BIT_CLKS * (9 + PAR) + 1;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ferr_o;
  logic       perr_o;
  logic       busy_o;

  uart_rx_sampler #(
    .CLK_HZ(3200000),
    .BAUD  (100000)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .rx_i   (rx_i),
    .data_o (data_o),
    .valid_o(valid_o),
    .ferr_o (ferr_o),
    .perr_o (perr_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur_ev;
  logic [2:0] exp_p;
  logic [7:0] model_data = 8'h00;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         last_valid_cyc = 0;
  int         n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_i === 1'b1) begin
      model_data = 8'h00;
      exp_q.delete();
    end
  end

  // Per-cycle comparison of pulses and held data against the model's event list.
  always @(negedge clk) begin
    exp_p = 3'b000;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      cur_ev = exp_q.pop_front();
      exp_p  = {cur_ev.v, cur_ev.f, cur_ev.p};
      if (cur_ev.v) model_data = cur_ev.d;
    end
    chk("pulses{valid,ferr,perr}", {29'd0, valid_o, ferr_o, perr_o}, {29'd0, exp_p});
    chk("data_o", {24'd0, data_o}, {24'd0, model_data});
    if (valid_o === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (ferr_o === 1'b1) ferr_cnt++;
    if (perr_o === 1'b1) perr_cnt++;
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok,
                            output int n_o);
    ev_t e;
    n_o = cyc;
    e.cyc = n_o + LAT;
    e.v   = stop_b;
    e.f   = !stop_b;
    e.p   = (PAR == 1) && !par_ok;
    e.d   = d;
    exp_q.push_back(e);
    drive_bit(1'b0);
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ !par_ok);
`endif
    drive_bit(stop_b);
    $display("frame data=0x%02h stop=%0b parity_ok=%0b start_cycle=%0d", d, stop_b, par_ok, n_o);
  endtask

  initial begin
    rx_i  = 1'b1;
    rst_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_data", {24'd0, data_o}, 32'h00);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h55, 1'b1, 1'b1, n);
    repeat (40) @(negedge clk);
    chk("good_busy_idle", {31'd0, busy_o}, 32'd0);
    chk("good_data_55", {24'd0, data_o}, 32'h55);
    chk("good_latency", last_valid_cyc - n, (PAR == 1) ? 32'd339 : 32'd307);

    // bad stop bit, then the line stays low as a break
    send_frame(8'hA3, 1'b0, 1'b1, n);
    repeat (96) @(negedge clk);
    chk("break_no_retrigger", {31'd0, busy_o}, 32'd0);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("ferr_data_kept", {24'd0, data_o}, 32'h55);
    chk("ferr_count", ferr_cnt, 32'd1);
    chk("valid_count_1", valid_cnt, 32'd1);

    n = cyc;
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    chk("glitch_busy_high", {31'd0, busy_o}, 32'd1);
    repeat (15) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy_o}, 32'd0);
    $display("glitch low=5 clocks start_cycle=%0d", n);
    repeat (30) @(negedge clk);

    // reset pulse in the middle of data bit 4 of 0x0F
    n = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (BIT_CLKS - 11) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(1'b0);
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0);
`endif
    drive_bit(1'b1);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_data", {24'd0, data_o}, 32'h00);
    $display("frame data=0x0f aborted by reset start_cycle=%0d", n);
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b1, n);
    repeat (40) @(negedge clk);
    chk("after_rst_data_3c", {24'd0, data_o}, 32'h3C);

    send_frame(8'h01, 1'b1, 1'b1, n);
    send_frame(8'hFF, 1'b1, 1'b1, n);
    repeat (40) @(negedge clk);
    chk("b2b_data_ff", {24'd0, data_o}, 32'hFF);
    chk("valid_count_4", valid_cnt, 32'd4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, n);
    repeat (40) @(negedge clk);
    chk("parity_data_07", {24'd0, data_o}, 32'h07);
    chk("perr_count", perr_cnt, 32'd1);
    chk("valid_count_5", valid_cnt, 32'd5);
`else
    chk("perr_count", perr_cnt, 32'd0);
`endif

    chk("pending_events", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
